// File: rtl/ysyx_cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
// Optional feature macro: YSYX_CDB_PERF_EN (per-requester grant/stall counters).
// YSYX_ROB_SIZE and YSYX_XLEN fall back to 16 / 32 when the core does not define them.

`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 16
`endif

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_cdb_pkg;

    localparam int CDB_NREQ  = 3;
    localparam int CDB_ROB_W = $clog2(`YSYX_ROB_SIZE) + 1;
    localparam int CDB_XLEN  = `YSYX_XLEN;
    localparam int CDB_SRC_W = $clog2(CDB_NREQ);

    localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU = CDB_SRC_W'(0);
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_LSU = CDB_SRC_W'(1);
    localparam logic [CDB_SRC_W-1:0] CDB_SRC_SYS = CDB_SRC_W'(2);

    typedef struct packed {
        logic [CDB_ROB_W-1:0] dest;
        logic [4:0]           rd;
        logic [CDB_XLEN-1:0]  result;
        logic [CDB_XLEN-1:0]  npc;
        logic                 br_retire;
        logic                 sys_retire;
    } cdb_pkt_t;

    // Round-robin successor of a grant index, wrapping the last requester back to 0.
    function automatic logic [CDB_SRC_W-1:0] cdb_rr_next(input logic [CDB_SRC_W-1:0] idx);
        if (idx == CDB_SRC_W'(CDB_NREQ - 1)) begin
            return '0;
        end
        return idx + CDB_SRC_W'(1);
    endfunction

endpackage

// File: rtl/ysyx_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, modulo NREQ.
// rr_ptr is expected to stay within 0..NREQ-1.

module ysyx_rr_picker
    import ysyx_cdb_pkg::*;
#(
    parameter int NREQ  = CDB_NREQ,
    parameter int SRC_W = CDB_SRC_W
) (
    input  logic [NREQ-1:0]  req_valid,
    input  logic [SRC_W-1:0] rr_ptr,
    output logic             pick_valid,
    output logic [SRC_W-1:0] pick
);

    int               idx;
    logic [SRC_W-1:0] idx_w;

    // Scan offsets from the far end toward rr_ptr so the closest valid requester wins last.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        idx_w      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = SRC_W'(idx);
            if (req_valid[idx_w]) begin
                pick_valid = 1'b1;
                pick       = idx_w;
            end
        end
    end

endmodule

// File: rtl/ysyx_cdb_arbiter.sv
// Common-data-bus arbiter: round-robin grant of FU results into a single registered
// output slot with valid/ready toward the ROB, plus flush squash.
// Optional feature macro: YSYX_CDB_PERF_EN enables per-requester grant and stall
// counters; without it perf_grant/perf_stall are constant zero.

module ysyx_cdb_arbiter
    import ysyx_cdb_pkg::*;
#(
    parameter int NREQ = CDB_NREQ
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  cdb_pkt_t [NREQ-1:0]   req_pkt,
    output logic                  cdb_valid,
    input  logic                  cdb_ready,
    output cdb_pkt_t              cdb_pkt,
    output logic [$clog2(NREQ)-1:0] cdb_src,
    output logic [NREQ-1:0][31:0] perf_grant,
    output logic [NREQ-1:0][31:0] perf_stall
);

    localparam int SRC_W = $clog2(NREQ);

    logic [SRC_W-1:0] rr_ptr;
    logic [SRC_W-1:0] pick;
    logic             pick_valid;
    logic             load_en;
    logic             accept;
    logic [SRC_W-1:0] rr_next;

    ysyx_rr_picker #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_picker (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    // The slot can take a new result when it is empty or being drained this cycle.
    assign load_en = !flush && (!cdb_valid || cdb_ready);
    assign accept  = |req_ready;
    assign rr_next = (pick == SRC_W'(NREQ - 1)) ? '0 : pick + SRC_W'(1);

    // One-hot grant; held low while reset is asserted so nothing is dropped into a clearing slot.
    always_comb begin
        req_ready = '0;
        if (reset && load_en && pick_valid) begin
            req_ready[pick] = 1'b1;
        end
    end

    // Output slot: flush squashes, accept loads, a bare handshake empties.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_pkt   <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (accept) begin
            cdb_valid <= 1'b1;
            cdb_pkt   <= req_pkt[pick];
            cdb_src   <= pick;
        end else if (cdb_ready) begin
            cdb_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the winner only on an actual accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_next;
        end
    end

`ifdef YSYX_CDB_PERF_EN
    logic [NREQ-1:0][31:0] grant_cnt;
    logic [NREQ-1:0][31:0] stall_cnt;

    // Free-running wrap-around counters; flush deliberately leaves them alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 32'd1;
                end
                if (req_valid[i] && !req_ready[i]) begin
                    stall_cnt[i] <= stall_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign perf_grant = grant_cnt;
    assign perf_stall = stall_cnt;
`else
    assign perf_grant = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ysyx_cdb_arbiter.sv
// Directed self-checking bench for ysyx_cdb_arbiter.

module tb_ysyx_cdb_arbiter;
    import ysyx_cdb_pkg::*;

`ifdef YSYX_CDB_PERF_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic                  clock;
    logic                  reset;
    logic                  flush;
    logic [2:0]            req_valid;
    logic [2:0]            req_ready;
    cdb_pkt_t [2:0]        req_pkt;
    logic                  cdb_valid;
    logic                  cdb_ready;
    cdb_pkt_t              cdb_pkt;
    logic [1:0]            cdb_src;
    logic [2:0][31:0]      perf_grant;
    logic [2:0][31:0]      perf_stall;

    int errors = 0;
    int checks = 0;

    ysyx_cdb_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pkt    (req_pkt),
        .cdb_valid  (cdb_valid),
        .cdb_ready  (cdb_ready),
        .cdb_pkt    (cdb_pkt),
        .cdb_src    (cdb_src),
        .perf_grant (perf_grant),
        .perf_stall (perf_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic cdb_pkt_t mk(input int dest, input int rd, input logic [31:0] res,
                                    input logic [31:0] npc, input logic br, input logic sys);
        cdb_pkt_t p;
        p.dest       = CDB_ROB_W'(dest);
        p.rd         = 5'(rd);
        p.result     = CDB_XLEN'(res);
        p.npc        = CDB_XLEN'(npc);
        p.br_retire  = br;
        p.sys_retire = sys;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_src;
        reset     = 1'b0;
        flush     = 1'b0;
        req_valid = 3'b000;
        cdb_ready = 1'b0;
        req_pkt[0] = mk(5,  1, 32'hA0A0_0001, 32'h8000_0004, 1'b0, 1'b0);
        req_pkt[1] = mk(9,  2, 32'hB1B1_0002, 32'h8000_0008, 1'b1, 1'b0);
        req_pkt[2] = mk(14, 3, 32'hC2C2_0003, 32'h8000_000C, 1'b0, 1'b1);

        // reset state
        #3;
        req_valid = 3'b111;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(3'b000));
        chk("rst_cdb_valid", 128'(cdb_valid), 128'(1'b0));
        chk("rst_cdb_pkt", 128'(cdb_pkt), 128'(0));
        chk("rst_cdb_src", 128'(cdb_src), 128'(2'd0));
        chk("rst_perf_grant", 128'(perf_grant), 128'(0));
        chk("rst_perf_stall", 128'(perf_stall), 128'(0));
        req_valid = 3'b000;
        @(posedge clock);
        #2;
        reset = 1'b1;

        // single request
        req_valid = 3'b001;
        cdb_ready = 1'b1;
        #1;
        chk("single_ready", 128'(req_ready), 128'(3'b001));
        tick();
        chk("single_valid", 128'(cdb_valid), 128'(1'b1));
        chk("single_dest", 128'(cdb_pkt.dest), 128'(5));
        chk("single_src", 128'(cdb_src), 128'(2'd0));
        req_valid = 3'b000;
        #1;
        chk("idle_ready", 128'(req_ready), 128'(3'b000));
        tick();
        chk("drain_valid", 128'(cdb_valid), 128'(1'b0));

        // rr_ptr is 1: request 2 alone brings it back to 0
        req_valid = 3'b100;
        #1;
        chk("req2_ready", 128'(req_ready), 128'(3'b100));
        tick();
        chk("req2_src", 128'(cdb_src), 128'(2'd2));

        // all valid, ready held high: 0,1,2,0,1,2 with no bubbles
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            exp_src = k % 3;
            #1;
            chk($sformatf("rr_ready_%0d", k), 128'(req_ready), 128'(3'b001 << exp_src));
            tick();
            chk($sformatf("rr_valid_%0d", k), 128'(cdb_valid), 128'(1'b1));
            chk($sformatf("rr_src_%0d", k), 128'(cdb_src), 128'(exp_src));
            chk($sformatf("rr_pkt_%0d", k), 128'(cdb_pkt), 128'(req_pkt[exp_src]));
        end

        // backpressure: slot holds requester 2's result
        cdb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("bp_ready_%0d", k), 128'(req_ready), 128'(3'b000));
            tick();
            chk($sformatf("bp_valid_%0d", k), 128'(cdb_valid), 128'(1'b1));
            chk($sformatf("bp_pkt_%0d", k), 128'(cdb_pkt), 128'(req_pkt[2]));
            chk($sformatf("bp_src_%0d", k), 128'(cdb_src), 128'(2'd2));
        end

        // flush while stalled
        flush = 1'b1;
        #1;
        chk("flush_ready", 128'(req_ready), 128'(3'b000));
        tick();
        chk("flush_valid", 128'(cdb_valid), 128'(1'b0));
        flush = 1'b0;
        #1;
        chk("post_flush_ready", 128'(req_ready), 128'(3'b001));
        cdb_ready = 1'b1;
        tick();
        chk("post_flush_src", 128'(cdb_src), 128'(2'd0));

        // walk rr_ptr to 2, then wrap behaviour with partial requests
        req_valid = 3'b010;
        #1;
        chk("to2_ready", 128'(req_ready), 128'(3'b010));
        tick();
        chk("to2_src", 128'(cdb_src), 128'(2'd1));
        req_valid = 3'b011;
        #1;
        chk("wrap_ready", 128'(req_ready), 128'(3'b001));
        tick();
        chk("wrap_src", 128'(cdb_src), 128'(2'd0));
        req_valid = 3'b010;
        #1;
        chk("next1_ready", 128'(req_ready), 128'(3'b010));
        tick();
        chk("next1_src", 128'(cdb_src), 128'(2'd1));
        req_valid = 3'b111;
        #1;
        chk("ptr2_ready", 128'(req_ready), 128'(3'b100));
        tick();
        chk("ptr2_src", 128'(cdb_src), 128'(2'd2));

        // reset mid-transfer
        cdb_ready = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 128'(cdb_valid), 128'(1'b0));
        chk("midrst_ready", 128'(req_ready), 128'(3'b000));
        chk("midrst_grant", 128'(perf_grant), 128'(0));
        chk("midrst_stall", 128'(perf_stall), 128'(0));
        req_valid = 3'b000;
        tick();
        #1;
        reset = 1'b1;

        // requester 1 blocked three cycles, then granted
        req_valid = 3'b001;
        tick();
        req_valid = 3'b010;
        tick();
        tick();
        tick();
        cdb_ready = 1'b1;
        #1;
        chk("perf_req1_ready", 128'(req_ready), 128'(3'b010));
        tick();
        req_valid = 3'b000;
        #1;
        chk("perf_stall1", 128'(perf_stall[1]), 128'(PERF_ON * 3));
        chk("perf_grant1", 128'(perf_grant[1]), 128'(PERF_ON * 1));
        chk("perf_grant0", 128'(perf_grant[0]), 128'(PERF_ON * 1));
        chk("perf_stall0", 128'(perf_stall[0]), 128'(0));
        chk("perf_grant2", 128'(perf_grant[2]), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
